// File: rtl/niosii_debug_oci_arbiter.sv
// Two-requester round-robin arbiter in front of a single OCI register/memory resource.
// Accesses run one at a time; stalled accesses abort after TIMEOUT ISSUE cycles with err set.
module niosii_debug_oci_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_done,
    output logic              a_err,
    output logic [31:0]       a_rdata,

    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_done,
    output logic              b_err,
    output logic [31:0]       b_rdata,

    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_rdata
);

    // Counter only ever reaches TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRdWait,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;     // 0 = A, 1 = B
    logic                last_q, last_d;       // most recent grant, 0 = A, 1 = B
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [31:0]         a_rdata_q, a_rdata_d;
    logic [31:0]         b_rdata_q, b_rdata_d;
    logic                grant_b;

    // B wins when alone, or on a tie when A was granted last.
    assign grant_b = b_req && (!a_req || !last_q);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    owner_d = grant_b;
                    last_d  = grant_b;
                    wr_d    = grant_b ? b_wr    : a_wr;
                    addr_d  = grant_b ? b_addr  : a_addr;
                    wdata_d = grant_b ? b_wdata : a_wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mem_rd = !wr_q;
                mem_wr = wr_q;
                if (!mem_waitrequest) begin
                    state_d = wr_q ? StDone : StRdWait;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRdWait: begin
                // Resource returns read data exactly one cycle after acceptance.
                if (owner_q) begin
                    b_rdata_d = mem_rdata;
                end else begin
                    a_rdata_d = mem_rdata;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_done    = (state_q == StDone) && !owner_q;
    assign b_done    = (state_q == StDone) && owner_q;
    assign a_err     = a_done && err_q;
    assign b_err     = b_done && err_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_niosii_debug_oci_arbiter.sv
// Scenario bench for niosii_debug_oci_arbiter: completions are checked against a scoreboard
// of expected (owner, err, rdata) tuples pushed as each access is launched.
`timescale 1ns/1ps
module tb_niosii_debug_oci_arbiter;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_req, a_wr, b_req, b_wr;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [31:0]       a_wdata, b_wdata;
    logic              a_done, a_err, b_done, b_err;
    logic [31:0]       a_rdata, b_rdata;
    logic              mem_rd, mem_wr, mem_waitrequest;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0BAD_0BAD;
    logic [31:0]       rd_value = 32'h0;

    always #5 clk = ~clk;

    niosii_debug_oci_arbiter #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .a_req           (a_req),
        .a_wr            (a_wr),
        .a_addr          (a_addr),
        .a_wdata         (a_wdata),
        .a_done          (a_done),
        .a_err           (a_err),
        .a_rdata         (a_rdata),
        .b_req           (b_req),
        .b_wr            (b_wr),
        .b_addr          (b_addr),
        .b_wdata         (b_wdata),
        .b_done          (b_done),
        .b_err           (b_err),
        .b_rdata         (b_rdata),
        .mem_rd          (mem_rd),
        .mem_wr          (mem_wr),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_waitrequest (mem_waitrequest),
        .mem_rdata       (mem_rdata)
    );

    // Resource model: read data valid only in the cycle after an accepted read.
    always @(posedge clk) begin
        if (mem_rd && !mem_waitrequest) mem_rdata <= rd_value;
        else                            mem_rdata <= 32'h0BAD_0BAD;
    end

    typedef struct {
        bit          who_b;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_a_rdata = 32'h0;
    logic [31:0] exp_b_rdata = 32'h0;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                total++;
                if (mem_rd && mem_wr) begin
                    bad++;
                    $display("FAIL strobes: mem_rd=%b mem_wr=%b, required not both high", mem_rd, mem_wr);
                end
                if (a_done || b_done) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_done: a_done=%b b_done=%b, required none", a_done, b_done);
                    end else begin
                        e = sb.pop_front();
                        if (a_done && b_done) begin
                            bad++;
                            $display("FAIL both_done: a_done=1 b_done=1, required one");
                        end else if (b_done !== e.who_b) begin
                            bad++;
                            $display("FAIL owner: b_done=%b, required %b", b_done, e.who_b);
                        end else if ((e.who_b ? b_err : a_err) !== e.err) begin
                            bad++;
                            $display("FAIL err: got %b, required %b", e.who_b ? b_err : a_err, e.err);
                        end else if ((e.who_b ? b_rdata : a_rdata) !== e.rdata) begin
                            bad++;
                            $display("FAIL rdata: got %h, required %h",
                                     e.who_b ? b_rdata : a_rdata, e.rdata);
                        end
                    end
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_a_rdata = 32'h0;
        exp_b_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        mem_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rst_a_done: got %b, required 0", a_done); end
        total++; if (b_done !== 1'b0) begin bad++; $display("FAIL rst_b_done: got %b, required 0", b_done); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rst_a_err: got %b, required 0", a_err); end
        total++; if (b_err !== 1'b0) begin bad++; $display("FAIL rst_b_err: got %b, required 0", b_err); end
        total++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            bad++; $display("FAIL rst_strobes: rd=%b wr=%b, required 0 0", mem_rd, mem_wr);
        end
        total++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
            bad++; $display("FAIL rst_rdata: a=%h b=%h, required 0 0", a_rdata, b_rdata);
        end
        total++; if (mem_addr !== '0 || mem_wdata !== 32'h0) begin
            bad++; $display("FAIL rst_mem_bus: addr=%h wdata=%h, required 0 0", mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_write_a();
        @(posedge clk); #1;
        a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h10; a_wdata = 32'hDEADBEEF;
        sb.push_back('{1'b0, 1'b0, exp_a_rdata});
        @(negedge clk);  // cycle 0, still idle
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL wr_c0: mem_wr=%b, required 0", mem_wr); end
        @(negedge clk);  // cycle 1
        total++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 8'h10 || mem_wdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_issue: wr=%b rd=%b addr=%h wdata=%h, required 1 0 10 deadbeef",
                     mem_wr, mem_rd, mem_addr, mem_wdata);
        end
        @(negedge clk);  // cycle 2
        total++; if (a_done !== 1'b1 || a_err !== 1'b0) begin
            bad++; $display("FAIL wr_done_c2: done=%b err=%b, required 1 0", a_done, a_err);
        end
        a_req = 1'b0;
        @(negedge clk);
        total++; if (a_done !== 1'b0 || mem_wr !== 1'b0) begin
            bad++; $display("FAIL wr_pulse: done=%b mem_wr=%b, required 0 0", a_done, mem_wr);
        end
    endtask

    task automatic test_read_b();
        @(posedge clk); #1;
        rd_value = 32'h12345678;
        b_req = 1'b1; b_wr = 1'b0; b_addr = 8'h05;
        exp_b_rdata = 32'h12345678;
        sb.push_back('{1'b1, 1'b0, exp_b_rdata});
        @(negedge clk);
        @(negedge clk);  // cycle 1
        total++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 8'h05) begin
            bad++; $display("FAIL rd_issue: rd=%b wr=%b addr=%h, required 1 0 05", mem_rd, mem_wr, mem_addr);
        end
        @(negedge clk);  // cycle 2
        total++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || b_done !== 1'b0) begin
            bad++; $display("FAIL rd_wait: rd=%b wr=%b done=%b, required 0 0 0", mem_rd, mem_wr, b_done);
        end
        @(negedge clk);  // cycle 3
        total++; if (b_done !== 1'b1 || b_rdata !== 32'h12345678 || a_done !== 1'b0) begin
            bad++;
            $display("FAIL rd_done_c3: b_done=%b b_rdata=%h a_done=%b, required 1 12345678 0",
                     b_done, b_rdata, a_done);
        end
        b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        bit order [3];
        int n;
        order[0] = 1'b0; order[1] = 1'b1; order[2] = 1'b0;
        n = 0;
        apply_reset();
        @(posedge clk); #1;
        a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h20; a_wdata = 32'hA0A0A0A0;
        b_req = 1'b1; b_wr = 1'b1; b_addr = 8'h30; b_wdata = 32'hB0B0B0B0;
        for (int k = 0; k < 3; k++) sb.push_back('{order[k], 1'b0, order[k] ? exp_b_rdata : exp_a_rdata});
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (mem_wr) begin
                total++;
                if (mem_addr !== (order[n] ? 8'h30 : 8'h20)) begin
                    bad++; $display("FAIL rr_addr: got %h, required %h", mem_addr, order[n] ? 8'h30 : 8'h20);
                end
            end
            if (a_done || b_done) begin
                total++;
                if (b_done !== order[n]) begin
                    bad++; $display("FAIL rr_order: grant %0d went to b=%b, required b=%b", n, b_done, order[n]);
                end
                n++;
                if (n == 3) begin a_req = 1'b0; b_req = 1'b0; end
            end
        end
        total++; if (n != 3) begin
            bad++; $display("FAIL rr_timeout: completions=%0d, required 3", n);
            a_req = 1'b0; b_req = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int issues;
        bit seen;
        // Seed A's rdata with a known value that the aborted read must not disturb.
        @(posedge clk); #1;
        rd_value = 32'hCAFEF00D;
        a_req = 1'b1; a_wr = 1'b0; a_addr = 8'h07;
        exp_a_rdata = 32'hCAFEF00D;
        sb.push_back('{1'b0, 1'b0, exp_a_rdata});
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (a_done) begin seen = 1'b1; a_req = 1'b0; end
        end
        total++; if (!seen) begin bad++; $display("FAIL to_seed: a_done=0, required 1"); a_req = 1'b0; end
        @(posedge clk); #1;
        mem_waitrequest = 1'b1;
        rd_value = 32'h11111111;
        a_req = 1'b1; a_wr = 1'b0; a_addr = 8'h07;
        sb.push_back('{1'b0, 1'b1, exp_a_rdata});
        issues = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_rd) issues++;
            if (a_done) begin seen = 1'b1; a_req = 1'b0; end
        end
        total++; if (!seen || issues != TIMEOUT) begin
            bad++; $display("FAIL to_cycles: done=%b issue_cycles=%0d, required 1 %0d", seen, issues, TIMEOUT);
            a_req = 1'b0;
        end
        @(posedge clk); #1;
        mem_waitrequest = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        bit seen, issued;
        @(posedge clk); #1;
        mem_waitrequest = 1'b1;
        a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h44; a_wdata = 32'h55AA55AA;
        @(negedge clk);
        @(negedge clk);
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL rm_issue: mem_wr=%b, required 1", mem_wr); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (mem_wr !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0 || a_done !== 1'b0) begin
            bad++;
            $display("FAIL rm_clear: wr=%b addr=%h wdata=%h done=%b, required 0 00 0 0",
                     mem_wr, mem_addr, mem_wdata, a_done);
        end
        @(posedge clk); #1;
        mem_waitrequest = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_a_rdata = 32'h0; exp_b_rdata = 32'h0;
        sb.push_back('{1'b0, 1'b0, exp_a_rdata});
        seen = 1'b0; issued = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mem_wr) begin
                issued = 1'b1;
                total++;
                if (mem_addr !== 8'h44) begin bad++; $display("FAIL rm_addr: got %h, required 44", mem_addr); end
            end
            if (a_done) begin seen = 1'b1; a_req = 1'b0; end
        end
        total++; if (!seen || !issued) begin
            bad++; $display("FAIL rm_reissue: issued=%b done=%b, required 1 1", issued, seen);
            a_req = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        @(posedge clk); #1;
        b_req = 1'b1; b_wr = 1'b1; b_addr = 8'h66; b_wdata = 32'h0F0F0F0F;
        sb.push_back('{1'b1, 1'b0, exp_b_rdata});
        @(negedge clk);
        @(negedge clk);  // ISSUE
        total++; if (mem_wr !== 1'b1 || mem_addr !== 8'h66) begin
            bad++; $display("FAIL dr_issue: wr=%b addr=%h, required 1 66", mem_wr, mem_addr);
        end
        b_req = 1'b0;
        @(negedge clk);
        total++; if (b_done !== 1'b1) begin bad++; $display("FAIL dr_done: b_done=%b, required 1", b_done); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || b_done !== 1'b0) begin
                bad++; $display("FAIL dr_quiet: wr=%b rd=%b done=%b, required 0 0 0", mem_wr, mem_rd, b_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int done_cyc [2];
        int n;
        n = 0; done_cyc[0] = -1; done_cyc[1] = -1;
        @(posedge clk); #1;
        a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h7F; a_wdata = 32'h13579BDF;
        sb.push_back('{1'b0, 1'b0, exp_a_rdata});
        sb.push_back('{1'b0, 1'b0, exp_a_rdata});
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            if (a_done) begin
                done_cyc[n] = c;
                n++;
                if (n == 2) a_req = 1'b0;
            end
        end
        total++; if (done_cyc[0] != 2 || done_cyc[1] != 5) begin
            bad++; $display("FAIL b2b_cycles: done at %0d and %0d, required 2 and 5", done_cyc[0], done_cyc[1]);
            a_req = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_write_a();
        test_read_b();
        test_round_robin();
        test_timeout();
        test_reset_mid_access();
        test_drop_req();
        test_back_to_back();
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_drain: %0d completions outstanding, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/niosii_debug_oci_arbiter.md
NIOSII_DEBUG_OCI_ARBITER -- requirements
Module: niosii_debug_oci_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: OCI register/memory word-address width.
REQ-002 Parameter TIMEOUT, default 255: maximum number of ISSUE cycles with mem_waitrequest high before the access is aborted; range 1..65535.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 a_req / b_req  input  1 each  access request from requester A (JTAG sysclk command path) and requester B (host CSR port); held high until the matching done pulse.
REQ-006 a_wr / b_wr  input  1 each  1 = write, 0 = read; sampled with req.
REQ-007 a_addr / b_addr  input  ADDR_W each  word address.
REQ-008 a_wdata / b_wdata  input  32 each  write data.
REQ-009 a_done / b_done  output  1 each  one-cycle completion pulse.
REQ-010 a_err / b_err  output  1 each  timeout flag, valid only while the matching done is high.
REQ-011 a_rdata / b_rdata  output  32 each  read data, valid while done is high and held until the next completion for that requester.
REQ-012 mem_rd / mem_wr  output  1 each  read and write strobes to the OCI resource.
REQ-013 mem_addr  output  ADDR_W  resource address; mem_wdata  output  32  resource write data.
REQ-014 mem_waitrequest  input  1  resource stall; mem_rdata  input  32  read data, valid exactly one cycle after a read is accepted.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, RDWAIT, DONE.
REQ-016 IDLE: if either req is high, the arbiter SHALL select a winner, latch its wr/addr/wdata, clear the timeout counter, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: if both reqs are high, the requester not granted most recently wins; a lone request wins immediately.
REQ-018 Requests SHALL be sampled only in IDLE; req changes in other states SHALL be ignored.
REQ-019 ISSUE: mem_rd or mem_wr SHALL be high, per the latched wr, with mem_addr and mem_wdata driven from the latched command.
REQ-020 In ISSUE with mem_waitrequest low, the FSM SHALL go to DONE for a write or to RDWAIT for a read.
REQ-021 In ISSUE with mem_waitrequest high, the counter SHALL increment; when the counter equals TIMEOUT-1 and mem_waitrequest is still high, the FSM SHALL set the error flag and go to DONE.
REQ-022 RDWAIT: the arbiter SHALL capture mem_rdata into the owner's rdata register and go to DONE; mem_rd and mem_wr SHALL be low.
REQ-023 DONE: the owner's done SHALL pulse for one cycle with err, then the FSM SHALL return to IDLE; the non-owner's done SHALL stay low.
REQ-024 Latency, with req rising before clock edge 0 and no wait: a write SHALL complete with done high in cycle 2, and a read with done high in cycle 3.
REQ-025 A timed-out read SHALL leave the owner's rdata unchanged.
REQ-026 If the owner drops req mid-access, the access SHALL still complete and done SHALL still pulse.
REQ-027 If req is still high in the IDLE cycle after DONE, it SHALL be treated as a new request, subject to round-robin.
REQ-028 Exactly one of mem_rd and mem_wr SHALL be high in ISSUE, and both SHALL be low in every other state.

Reset
REQ-029 Reset assertion SHALL immediately force: state IDLE; all done, err, mem_rd and mem_wr low; rdata, mem_addr and mem_wdata zero; counter zero; last-grant set to B, so A wins the first tie.
REQ-030 Reset mid-access SHALL abort the access with no done pulse; after release, a held req SHALL restart from IDLE.

Verification
REQ-031 a_req write, addr 0x10, data 0xDEADBEEF, waitrequest low -> mem_wr high cycle 1 at 0x10; a_done cycle 2; a_err 0.
REQ-032 b_req read, addr 0x05, mem_rdata 0x12345678 one cycle after acceptance -> b_done cycle 3, b_rdata 0x12345678.
REQ-033 a_req and b_req rise together after reset, both held -> A served first, then B, then A again.
REQ-034 TIMEOUT=4, waitrequest stuck high on a read -> 4 ISSUE cycles, then done with err=1 and rdata unchanged.
REQ-035 reset pulsed during ISSUE with req held -> outputs clear immediately, no done; access reissued after release.
REQ-036 Owner drops req in ISSUE -> access completes and done still pulses.
